// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants, FSM encoding and debug view for the OAM DMA controller.
package oam_dma_ctrl_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
   localparam logic [7:0]  OPEN_BUS     = 8'hFF;
   localparam logic [7:0]  ECHO_BASE    = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET  = 8'h20;

   localparam logic [1:0]  T_PH0 = 2'd0;
   localparam logic [1:0]  T_PH1 = 2'd1;
   localparam logic [1:0]  T_PH2 = 2'd2;
   localparam logic [1:0]  T_PH3 = 2'd3;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_e;

   typedef struct packed {
      dma_state_e state;
      logic [7:0] idx;
      logic [7:0] page;
   } dma_dbg_t;

   // Pages E0-FF are echo RAM; the copy reads the underlying C0-DF page instead.
   function automatic logic [7:0] src_page_of(input logic [7:0] page);
      return (page >= ECHO_BASE) ? (page - ECHO_OFFSET) : page;
   endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side, system-bus and OAM-side signals of the DMA controller, plus its debug view.
interface oam_dma_ctrl_if;
   import oam_dma_ctrl_pkg::*;

   logic [1:0]  t_cycle;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        oam_wr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        dma_active;
   dma_dbg_t    dbg;

   modport slave (
      input  t_cycle, cpu_addr, cpu_wr, cpu_wdata, mem_rdata,
      output cpu_rdata, mem_addr, mem_wr, mem_wdata,
      output oam_wr, oam_addr, oam_wdata, dma_active, dbg
   );

   modport master (
      output t_cycle, cpu_addr, cpu_wr, cpu_wdata, mem_rdata,
      input  cpu_rdata, mem_addr, mem_wr, mem_wdata,
      input  oam_wr, oam_addr, oam_wdata, dma_active, dbg
   );

endinterface

// File: rtl/oam_dma_ctrl_bus_mux.sv
// Combinational CPU/DMA arbitration of the system bus address, write strobe and CPU read data.
module dma_bus_mux
   import oam_dma_ctrl_pkg::*;
(
   input  logic        xfer_i,
   input  logic [1:0]  t_cycle_i,
   input  logic [15:0] cpu_addr_i,
   input  logic        cpu_wr_i,
   input  logic [7:0]  mem_rdata_i,
   input  logic [7:0]  page_i,
   input  logic [15:0] dma_addr_i,
   output logic [7:0]  cpu_rdata_o,
   output logic [15:0] mem_addr_o,
   output logic        mem_wr_d_o
);

   logic cpu_high;
   logic cpu_slot;

   always_comb begin
      cpu_high    = (cpu_addr_i[15:8] == HIGH_PAGE);
      cpu_slot    = cpu_high && ((t_cycle_i == T_PH0) || (t_cycle_i == T_PH3));
      cpu_rdata_o = mem_rdata_i;
      mem_addr_o  = cpu_addr_i;
      mem_wr_d_o  = cpu_wr_i;

      if (cpu_addr_i == DMA_REG_ADDR) begin
         cpu_rdata_o = page_i;
      end else if (xfer_i && !cpu_high) begin
         cpu_rdata_o = OPEN_BUS;
      end

      // The DMA owns phases 1-2; a high-page write is only registered from phase 3
      // so the strobe lands in phase 0, while the CPU still holds the address.
      if (xfer_i) begin
         mem_addr_o = cpu_slot ? cpu_addr_i : dma_addr_i;
         mem_wr_d_o = cpu_wr_i && cpu_high && (t_cycle_i == T_PH3);
      end
   end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: an FF46 write starts a page-to-OAM copy of one byte per M-cycle.
// START_DELAY must be at least 1.
module oam_dma_ctrl
   import oam_dma_ctrl_pkg::*;
#(
   parameter int DMA_LEN     = 160,
   parameter int START_DELAY = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   oam_dma_ctrl_if.slave bus
);

   localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
   localparam logic [7:0] LAST_WAIT = 8'(START_DELAY - 1);

   dma_state_e  state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  src_q, src_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  wait_q, wait_d;
   logic        armed_q, armed_d;
   logic        oam_wr_q, oam_wr_d;
   logic [7:0]  oam_addr_q, oam_addr_d;
   logic [7:0]  oam_wdata_q, oam_wdata_d;
   logic        active_q, active_d;
   logic        mem_wr_q, mem_wr_d;
   logic [7:0]  mem_wdata_q;

   logic        reg_wr;
   logic        xfer;
   logic [15:0] dma_addr;
   logic [15:0] mem_addr_mux;
   logic [7:0]  cpu_rdata_mux;

   assign reg_wr   = bus.cpu_wr && (bus.t_cycle == T_PH2) && (bus.cpu_addr == DMA_REG_ADDR);
   assign xfer     = (state_q == DMA_XFER);
   assign dma_addr = {src_q, idx_q};

   dma_bus_mux u_bus_mux (
      .xfer_i      (xfer),
      .t_cycle_i   (bus.t_cycle),
      .cpu_addr_i  (bus.cpu_addr),
      .cpu_wr_i    (bus.cpu_wr),
      .mem_rdata_i (bus.mem_rdata),
      .page_i      (page_q),
      .dma_addr_i  (dma_addr),
      .cpu_rdata_o (cpu_rdata_mux),
      .mem_addr_o  (mem_addr_mux),
      .mem_wr_d_o  (mem_wr_d)
   );

   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      src_d       = src_q;
      idx_d       = idx_q;
      wait_d      = wait_q;
      armed_d     = armed_q;
      oam_wr_d    = 1'b0;
      oam_addr_d  = oam_addr_q;
      oam_wdata_d = oam_wdata_q;
      active_d    = active_q;

      case (state_q)
         DMA_START: begin
            // The partial M-cycle holding the FF46 write must not count as a wait cycle.
            if (bus.t_cycle == T_PH0) begin
               armed_d = 1'b1;
            end
            if ((bus.t_cycle == T_PH3) && armed_q) begin
               if (wait_q == LAST_WAIT) begin
                  state_d = DMA_XFER;
                  wait_d  = 8'd0;
               end else begin
                  wait_d  = wait_q + 8'd1;
               end
            end
         end
         DMA_XFER: begin
            if (bus.t_cycle == T_PH2) begin
               oam_wr_d    = 1'b1;
               oam_addr_d  = idx_q;
               oam_wdata_d = bus.mem_rdata;
            end
            if (bus.t_cycle == T_PH3) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DMA_IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
         end
         default: begin
         end
      endcase

      // A new FF46 write overrides any progress made above in the same clock.
      if (reg_wr) begin
         page_d  = bus.cpu_wdata;
         src_d   = src_page_of(bus.cpu_wdata);
         idx_d   = 8'd0;
         wait_d  = 8'd0;
         armed_d = 1'b0;
         state_d = DMA_START;
      end

      if (bus.t_cycle == T_PH3) begin
         active_d = (state_d != DMA_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DMA_IDLE;
         page_q      <= 8'h00;
         src_q       <= 8'h00;
         idx_q       <= 8'h00;
         wait_q      <= 8'h00;
         armed_q     <= 1'b0;
         oam_wr_q    <= 1'b0;
         oam_addr_q  <= 8'h00;
         oam_wdata_q <= 8'h00;
         active_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         page_q      <= page_d;
         src_q       <= src_d;
         idx_q       <= idx_d;
         wait_q      <= wait_d;
         armed_q     <= armed_d;
         oam_wr_q    <= oam_wr_d;
         oam_addr_q  <= oam_addr_d;
         oam_wdata_q <= oam_wdata_d;
         active_q    <= active_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= bus.cpu_wdata;
      end
   end

   assign bus.cpu_rdata  = cpu_rdata_mux;
   assign bus.mem_addr   = mem_addr_mux;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.oam_wr     = oam_wr_q;
   assign bus.oam_addr   = oam_addr_q;
   assign bus.oam_wdata  = oam_wdata_q;
   assign bus.dma_active = active_q;
   assign bus.dbg        = '{state: state_q, idx: idx_q, page: page_q};

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA sequencer and system-bus arbiter between the `cpu` core and the memory map. A CPU write to register FF46 starts a 160-byte copy from page `XX00` into OAM (FE00–FE9F). The block owns the external bus for the copy's duration. While it does, CPU accesses are confined to FF00–FFFF (I/O, HRAM, IE), and all other CPU accesses are blocked.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per transfer.
- `START_DELAY`, 1: idle M-cycles between the FF46 write and the first transfer M-cycle.

Ports:
- `clk`  in  1  T-cycle clock, same as `cpu`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `t_cycle`  in  2  T-phase of the current M-cycle, taken from `cpu`.
- `cpu_addr`  in  16  CPU address (`address_out`).
- `cpu_wr`  in  1  CPU write strobe.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  read data returned to the CPU (`data_in`).
- `mem_addr`  out  16  system bus address.
- `mem_wr`  out  1  system bus write.
- `mem_wdata`  out  8  system bus write data.
- `mem_rdata`  in  8  system bus read data.
- `oam_wr`  out  1  one-clk OAM write pulse.
- `oam_addr`  out  8  OAM byte index, 0–159.
- `oam_wdata`  out  8  OAM write data.
- `dma_active`  out  1  high in START and XFER.

## Operation
FSM states:
- IDLE: no transfer.
- START: waits `START_DELAY` M-cycles.
- XFER: copies `DMA_LEN` bytes, one per M-cycle.

FF46 writes:
- A CPU write to FF46 is taken when `t_cycle`==2 and `cpu_wr`=1.
- It latches `page` = `cpu_wdata` and `src_page` = (`cpu_wdata` ≥ E0 ? `cpu_wdata`−20h : `cpu_wdata`).
- It clears `idx` and moves the FSM to START from any state, so a write during START or XFER restarts the transfer. The partial copy is abandoned and OAM keeps the bytes already written.
- A CPU read of FF46 returns `page`. The write is also forwarded to the bus.

START to XFER:
- START lasts exactly `START_DELAY` full M-cycles.
- The counting M-cycles begin at the first `t_cycle`==0 after the write.
- The CPU is NOT blocked during START.

XFER, each M-cycle:
- `mem_addr` = {`src_page`, `idx`} for all four T-phases.
- `mem_wr`=0.
- At `t_cycle`==2: `oam_wdata` ← `mem_rdata`, `oam_addr` ← `idx`, `oam_wr` pulses for one clk.
- At `t_cycle`==3: `idx` increments. If `idx`==`DMA_LEN`−1, the FSM moves to IDLE instead of incrementing.

Bus arbitration:
- IDLE/START: all CPU signals pass through to the bus, and `cpu_rdata`=`mem_rdata` (FF46 reads excepted).
- XFER, `cpu_addr` ≥ FF00: the CPU access passes to the bus, but `mem_addr` stays the DMA address. FF00–FFFF is decoded off-bus by the I/O/HRAM path, which drives `mem_rdata` for those reads.
- XFER, `cpu_addr` < FF00: writes are dropped (`mem_wr`=0) and reads return FFh.
- Simplification: during XFER the block forwards `cpu_addr` to I/O/HRAM via the same `mem_*` port with `mem_addr` = `cpu_addr` only when `cpu_addr` ≥ FF00. On those T-cycles the DMA read is deferred. Because the DMA samples only at `t_cycle`==2, `mem_addr` must equal the DMA address at `t_cycle` 1–2. CPU high-page accesses therefore take the bus only at `t_cycle` 0 and 3.

Width rules: `idx` is 8 bits and never exceeds 159. There is no wrap-around.

## Timing
- Reset values: `cpu_rdata`=00, `mem_addr`=0000, `mem_wr`=0, `mem_wdata`=00, `oam_wr`=0, `oam_addr`=00, `oam_wdata`=00, `dma_active`=0, `page`=00, FSM=IDLE.
- Reset asserted mid-transfer aborts immediately, with no further OAM writes.
- Latency: first `oam_wr` occurs (`START_DELAY`+1) M-cycles after the FF46 write M-cycle, at `t_cycle`==2.
- Total: `dma_active` is high for `START_DELAY`+`DMA_LEN` = 161 M-cycles = 644 clks.
- `dma_active` rises at the `t_cycle`==3 following the write, and falls at the `t_cycle`==3 of the last transfer M-cycle.
- Simultaneous events: a restart write at `t_cycle`==2 of an XFER M-cycle still completes that M-cycle's OAM write. The restart takes priority over the idx increment and completion.
- All outputs are registered, except `cpu_rdata` and `mem_addr`, which are combinational muxes of registered state and inputs.

## Structure
- Shared package `common_defs.vh` gains:
  - `DMA_REG_ADDR` = FF46
  - `HIGH_PAGE` = FF
  - state encodings `DMA_IDLE`, `DMA_START`, `DMA_XFER`
  - `OPEN_BUS` = FF
- One natural sub-module: `dma_bus_mux`, the combinational CPU/DMA address and data arbitration.
- The FSM and counters stay in `oam_dma_ctrl`.

## Test plan
- Write C0 to FF46; memory C000+i holds i^5Ah → 160 `oam_wr` pulses, `oam_addr` 0..159, `oam_wdata`=i^5Ah, `dma_active` high for 644 clks.
- Write E1 to FF46 → `mem_addr` sequence starts C100 (echo mapped); FF46 reads back E1.
- During XFER: CPU reads 0150 → FFh; CPU writes C000 → no `mem_wr`; CPU reads FF85 → HRAM value returned.
- Write 80 then write 90 at `idx`=50 → OAM 0–49 hold 8000–8031 data, then `idx` restarts at 0 from 9000 after 1 M-cycle, 160 more writes.
- Assert `rst_n`=0 at `idx`=20 → `oam_wr`=0 and `dma_active`=0 immediately; after release the FSM is IDLE and no writes occur.
- Boundary: last M-cycle `oam_addr`=159 → no write to index 160, and the FSM is IDLE at the following `t_cycle`==0.
